compare_unit: RTL and testbench

Bit-serial comparator that executes the CMP instruction and produces the 8-bit `compare_flag` consumed by the branch decision logic. It scans the two operands MSB-first, one bit per clock, and stops at the first differing bit. It then latches a one-hot LT/EQ/GT result into a flag register that holds until the next completed compare. It sits in the execute stage beside the ALU and trades latency (1–8 cycles) for area.

---
 rtl/compare_unit.sv | 171 +++++++++++++++++
 tb/tb_compare_unit.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/compare_unit.sv
// -----------------------------------------------------------------------------
// compare_unit
//
// Bit-serial comparator for the CMP instruction. On accept it latches both
// 8-bit operands and the signed-mode bit. It then scans MSB-first, one bit per
// clock, and stops at the first differing bit. The one-hot LT/EQ/GT result is
// held in compare_flag until the next completed compare. Latency is 1..8 cycles.
//
// Ports:
//   clk          in   1  system clock, rising edge
//   rst_n        in   1  asynchronous active-low reset
//   start        in   1  instruction valid, sampled only while idle
//   instruction  in   8  [7:4] opcode, [3] signed mode, [2:0] ignored
//   operand_a    in   8  left operand, sampled on accept
//   operand_b    in   8  right operand, sampled on accept
//   flush        in   1  abort an in-flight compare / block accept
//   busy         out  1  compare in progress
//   done         out  1  one-cycle pulse, compare_flag updated on same edge
//   compare_flag out  8  [0] GT, [1] EQ, [2] LT, [7:3] always zero
// -----------------------------------------------------------------------------
package opcode_pkg;
    typedef enum logic [3:0] {
        OPCODE_NOP = 4'h0,
        OPCODE_ALU = 4'h1,
        OPCODE_CMP = 4'h2,
        OPCODE_BR  = 4'h3,
        OPCODE_LD  = 4'h4,
        OPCODE_ST  = 4'h5
    } opcode_t;
endpackage

module compare_unit
    import opcode_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] instruction,
    input  logic [7:0] operand_a,
    input  logic [7:0] operand_b,
    input  logic       flush,
    output logic       busy,
    output logic       done,
    output logic [7:0] compare_flag
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_SCAN = 1'b1;

    localparam logic [2:0] FLAG_GT = 3'b001;
    localparam logic [2:0] FLAG_EQ = 3'b010;
    localparam logic [2:0] FLAG_LT = 3'b100;

    localparam logic [2:0] IDX_MSB = 3'd7;

    // Result for the first differing bit. In signed mode the MSB is the sign
    // bit, so the operand holding a 1 there is the negative (smaller) one;
    // everywhere else the operand holding the 1 is the larger.
    function automatic logic [2:0] resolve_diff(input logic a_bit,
                                                input logic signed_mode,
                                                input logic is_msb);
        logic [2:0] res;
        if (signed_mode && is_msb) begin
            res = a_bit ? FLAG_LT : FLAG_GT;
        end else begin
            res = a_bit ? FLAG_GT : FLAG_LT;
        end
        return res;
    endfunction

    logic [0:0] state_q, state_d;
    logic [7:0] a_q, a_d;
    logic [7:0] b_q, b_d;
    logic       signed_q, signed_d;
    logic [2:0] idx_q, idx_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic [2:0] flag_q, flag_d;

    logic       accept_s;
    logic       bit_diff_s;
    logic       unused_instr_s;

    // Accept only a CMP with no flush in the same cycle.
    assign accept_s = start && !flush &&
                      (opcode_t'(instruction[7:4]) == OPCODE_CMP);

    assign bit_diff_s     = a_q[idx_q] ^ b_q[idx_q];
    assign unused_instr_s = ^instruction[2:0];

    // Next-state logic for the IDLE/SCAN sequencer and the result register.
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        signed_d = signed_q;
        idx_d    = idx_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        flag_d   = flag_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    a_d      = operand_a;
                    b_d      = operand_b;
                    signed_d = instruction[3];
                    idx_d    = IDX_MSB;
                    busy_d   = 1'b1;
                    state_d  = ST_SCAN;
                end else begin
                    busy_d = 1'b0;
                end
            end
            ST_SCAN: begin
                if (flush) begin
                    // Flush beats a completion on the same cycle.
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    idx_d   = IDX_MSB;
                end else if (bit_diff_s) begin
                    flag_d  = resolve_diff(a_q[idx_q], signed_q, idx_q == IDX_MSB);
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    idx_d   = IDX_MSB;
                    state_d = ST_IDLE;
                end else if (idx_q == 3'd0) begin
                    flag_d  = FLAG_EQ;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    idx_d   = IDX_MSB;
                    state_d = ST_IDLE;
                end else begin
                    idx_d = idx_q - 3'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                idx_d   = IDX_MSB;
            end
        endcase
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            a_q      <= 8'h00;
            b_q      <= 8'h00;
            signed_q <= 1'b0;
            idx_q    <= IDX_MSB;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            flag_q   <= 3'b000;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            signed_q <= signed_d;
            idx_q    <= idx_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            flag_q   <= flag_d;
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign compare_flag = {5'b00000, flag_q};

endmodule

// File: tb/tb_compare_unit.sv
module tb_compare_unit;
    import opcode_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] instruction;
    logic [7:0] operand_a;
    logic [7:0] operand_b;
    logic       flush;
    logic       busy;
    logic       done;
    logic [7:0] compare_flag;

    int errors = 0;
    int checks = 0;

    compare_unit dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .instruction  (instruction),
        .operand_a    (operand_a),
        .operand_b    (operand_b),
        .flush        (flush),
        .busy         (busy),
        .done         (done),
        .compare_flag (compare_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       sgn;
        logic [7:0] exp_flag;
        int         exp_lat;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: plain integer comparison of the operands as numbers.
    function automatic logic [7:0] model_flag(input logic [7:0] a, input logic [7:0] b, input logic sgn);
        int va, vb;
        va = sgn ? int'($signed(a)) : int'(a);
        vb = sgn ? int'($signed(b)) : int'(b);
        if (va > vb) return 8'h01;
        else if (va == vb) return 8'h02;
        else return 8'h04;
    endfunction

    // Reference latency: one cycle per bit examined, top down.
    function automatic int model_lat(input logic [7:0] a, input logic [7:0] b);
        for (int k = 7; k >= 0; k--) begin
            if (a[k] != b[k]) return 8 - k;
        end
        return 8;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one CMP and follow it to completion. Operands are scrambled after
    // accept; with interfere set, a second CMP start is driven mid-scan.
    task automatic run_cmp(input logic [7:0] a, input logic [7:0] b, input logic sgn,
                           input logic [7:0] exp_flag, input int exp_lat,
                           input string tag, input bit interfere);
        int cnt;
        int busy_cnt;
        bit seen;
        cnt = 0;
        busy_cnt = 0;
        seen = 1'b0;
        operand_a = a;
        operand_b = b;
        instruction = {OPCODE_CMP, sgn, 3'($urandom_range(0, 7))};
        start = 1'b1;
        tick();
        start = 1'b0;
        operand_a = 8'($urandom);
        operand_b = 8'($urandom);
        while (!seen && cnt < 20) begin
            if (done) begin
                seen = 1'b1;
            end else begin
                if (busy) busy_cnt++;
                if (interfere && cnt == 2) begin
                    start = 1'b1;
                    operand_a = ~a;
                    operand_b = b;
                    instruction = {OPCODE_CMP, ~sgn, 3'b000};
                end else begin
                    start = 1'b0;
                end
                tick();
                cnt++;
            end
        end
        start = 1'b0;
        check({tag, " done_seen"}, 32'(seen), 32'd1);
        check({tag, " latency"}, 32'(cnt), 32'(exp_lat));
        check({tag, " busy_cycles"}, 32'(busy_cnt), 32'(exp_lat));
        check({tag, " flag"}, 32'(compare_flag), 32'(exp_flag));
        check({tag, " busy_in_done"}, 32'(busy), 32'd0);
        tick();
        check({tag, " done_pulse_width"}, 32'(done), 32'd0);
    endtask

    // Watch idle outputs for n cycles: no busy, no done, flag held.
    task automatic idle_watch(input int n, input logic [7:0] held, input string tag);
        int bad;
        bad = 0;
        for (int i = 0; i < n; i++) begin
            if (busy || done || compare_flag != held) bad++;
            tick();
        end
        check({tag, " idle_hold"}, 32'(bad), 32'd0);
    endtask

    vec_t vecs[10];
    logic [7:0] last_flag;

    initial begin
        vecs[0] = '{8'h80, 8'h01, 1'b1, 8'h04, 1};
        vecs[1] = '{8'h80, 8'h01, 1'b0, 8'h01, 1};
        vecs[2] = '{8'h5A, 8'h5A, 1'b0, 8'h02, 8};
        vecs[3] = '{8'h10, 8'h11, 1'b0, 8'h04, 8};
        vecs[4] = '{8'hFF, 8'h7F, 1'b1, 8'h04, 1};
        vecs[5] = '{8'h7F, 8'hFF, 1'b1, 8'h01, 1};
        vecs[6] = '{8'hFF, 8'h7F, 1'b0, 8'h01, 1};
        vecs[7] = '{8'h00, 8'h00, 1'b1, 8'h02, 8};
        vecs[8] = '{8'h02, 8'h03, 1'b1, 8'h04, 8};
        vecs[9] = '{8'hF0, 8'hE0, 1'b1, 8'h01, 4};

        rst_n = 1'b0;
        start = 1'b0;
        flush = 1'b0;
        instruction = 8'h00;
        operand_a = 8'h00;
        operand_b = 8'h00;
        repeat (3) tick();
        check("reset flag", 32'(compare_flag), 32'h00);
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        rst_n = 1'b1;
        tick();

        // Directed table.
        for (int i = 0; i < 10; i++) begin
            run_cmp(vecs[i].a, vecs[i].b, vecs[i].sgn, vecs[i].exp_flag,
                    vecs[i].exp_lat, $sformatf("vec%0d", i), 1'b0);
        end
        last_flag = compare_flag;

        // Non-CMP opcode with start is ignored.
        instruction = {OPCODE_BR, 1'b0, 3'b000};
        operand_a = 8'h00;
        operand_b = 8'hFF;
        start = 1'b1;
        tick();
        start = 1'b0;
        idle_watch(4, last_flag, "noncmp");

        // start during SCAN is ignored.
        run_cmp(8'h10, 8'h11, 1'b0, 8'h04, 8, "start_in_scan", 1'b1);
        last_flag = compare_flag;

        // Flush at cycle 3 of SCAN.
        operand_a = 8'h01;
        operand_b = 8'h00;
        instruction = {OPCODE_CMP, 1'b0, 3'b000};
        start = 1'b1;
        tick();
        start = 1'b0;
        check("flush busy_c1", 32'(busy), 32'd1);
        tick();
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush busy_after", 32'(busy), 32'd0);
        idle_watch(10, last_flag, "flush");

        // flush + start in IDLE: not accepted.
        operand_a = 8'h80;
        operand_b = 8'h00;
        instruction = {OPCODE_CMP, 1'b0, 3'b000};
        start = 1'b1;
        flush = 1'b1;
        tick();
        start = 1'b0;
        flush = 1'b0;
        idle_watch(10, last_flag, "flush_start_idle");

        // Flush on the same cycle a 1-cycle compare would complete.
        start = 1'b1;
        tick();
        start = 1'b0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        idle_watch(4, last_flag, "flush_vs_done");

        // Back-to-back with zero gap.
        operand_a = 8'hFF;
        operand_b = 8'h7F;
        instruction = {OPCODE_CMP, 1'b1, 3'b000};
        start = 1'b1;
        tick();
        start = 1'b0;
        operand_a = 8'h7F;
        operand_b = 8'hFF;
        check("b2b busy1", 32'(busy), 32'd1);
        tick();
        check("b2b done1", 32'(done), 32'd1);
        check("b2b flag1", 32'(compare_flag), 32'h04);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("b2b busy2", 32'(busy), 32'd1);
        check("b2b done_gap", 32'(done), 32'd0);
        tick();
        check("b2b done2", 32'(done), 32'd1);
        check("b2b flag2", 32'(compare_flag), 32'h01);
        tick();

        // Randomized against the reference model.
        for (int i = 0; i < 60; i++) begin
            logic [7:0] ra, rb;
            logic rs;
            ra = 8'($urandom);
            rb = (i % 4 == 0) ? ra ^ (8'h01 << $urandom_range(0, 7)) : 8'($urandom);
            if (i % 7 == 0) rb = ra;
            rs = 1'($urandom);
            run_cmp(ra, rb, rs, model_flag(ra, rb, rs), model_lat(ra, rb),
                    $sformatf("rnd%0d", i), 1'b0);
            check("rnd upper_zero", 32'(compare_flag[7:3]), 32'd0);
        end

        // Reset mid-SCAN.
        operand_a = 8'h5A;
        operand_b = 8'h5A;
        instruction = {OPCODE_CMP, 1'b0, 3'b000};
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        check("rstmid busy_before", 32'(busy), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rstmid busy", 32'(busy), 32'd0);
        check("rstmid done", 32'(done), 32'd0);
        check("rstmid flag", 32'(compare_flag), 32'h00);
        tick();
        rst_n = 1'b1;
        idle_watch(10, 8'h00, "rstmid");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
